// File: rtl/novelty_pkg.sv
// Shared widths, default parameters and the event record for the novelty array.
package novelty_pkg;

    localparam int          DEF_N_CH       = 4;
    localparam int          DEF_DATA_W     = 8;
    localparam int          DEF_ACC_W      = 16;
    localparam int          DEF_W_DEPTH    = 16;
    localparam int          DEF_LEAK_SHIFT = 1;
    localparam int          DEF_CMP_LSB    = 4;
    localparam logic [7:0]  DEF_INIT_W     = 8'h10;

    // Channel index width; a single channel still gets a 1-bit index port.
    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

    // Weight pointer width; depth is a power of two, so the pointer wraps by overflow.
    function automatic int ptr_width(input int w_depth);
        return (w_depth > 1) ? $clog2(w_depth) : 1;
    endfunction

    localparam int DEF_CH_W = 2;

    // Event record at the default widths: channel that fired and its compared slice.
    typedef struct packed {
        logic [DEF_CH_W-1:0]   ch;
        logic [DEF_DATA_W-1:0] slice;
    } evt_rec_t;

endpackage

// File: rtl/novelty_weight_ram.sv
// Single-port weight store with synchronous read; a write owns the port for its cycle.
module novelty_weight_ram
    import novelty_pkg::*;
#(
    parameter int               CH_W   = 2,
    parameter int               PTR_W  = 4,
    parameter int               DATA_W = 8,
    parameter logic [DATA_W-1:0] INIT_W = 8'h10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic                    re,
    input  logic [CH_W+PTR_W-1:0]   addr,
    input  logic [DATA_W-1:0]       wdata,
    output logic [DATA_W-1:0]       rdata
);

    // Address is {ch, ptr}; rows for channel indices >= N_CH are never written or read.
    localparam int DEPTH = 1 << (CH_W + PTR_W);

    // Power-up contents come from the declaration; reset never touches the weights.
    logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: INIT_W};

    // Write wins over read on the single port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/leaky_novelty_array.sv
// Multi-channel leaky energy integrator with per-channel novelty flags and a
// one-deep ready/valid event register reporting novelty rising edges.
module leaky_novelty_array
    import novelty_pkg::*;
#(
    parameter int                N_CH       = DEF_N_CH,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter int                ACC_W      = DEF_ACC_W,
    parameter int                W_DEPTH    = DEF_W_DEPTH,
    parameter int                LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int                CMP_LSB    = DEF_CMP_LSB,
    parameter logic [DATA_W-1:0] INIT_W     = DEF_INIT_W,
    localparam int               CH_W       = ch_width(N_CH),
    localparam int               PTR_W      = ptr_width(W_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              soft_clr,
    input  logic              w_we,
    input  logic [CH_W-1:0]   w_ch,
    input  logic [PTR_W-1:0]  w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [N_CH-1:0]   novel,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic [DATA_W-1:0] evt_slice,
    output logic [N_CH-1:0]   sat,
    output logic [7:0]        drop_cnt
);

    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);

    logic [N_CH-1:0][ACC_W-1:0] energy;
    logic [N_CH-1:0][PTR_W-1:0] ptr;

    logic                    accept;
    logic                    in_rng;
    logic                    w_rng;
    logic                    ram_we;
    logic                    ram_re;
    logic [CH_W+PTR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]       weight;

    logic                    upd_valid;
    logic [CH_W-1:0]         upd_ch;
    logic [DATA_W-1:0]       upd_data;

    logic [ACC_W-1:0]        e_cur;
    logic [ACC_W:0]          sum;
    logic                    upd_sat;
    logic [ACC_W-1:0]        e_new;
    logic [DATA_W-1:0]       slice;
    logic                    hit;
    logic                    rise;
    logic                    can_load;

    // Weight writes and clears own the cycle, so samples are refused then.
    assign in_ready = ~w_we & ~soft_clr;
    assign accept   = in_valid & in_ready;
    assign in_rng   = ({1'b0, in_ch} < N_CH_L);
    assign w_rng    = ({1'b0, w_ch} < N_CH_L);
    assign ram_we   = w_we & w_rng;
    assign ram_re   = accept & in_rng;
    assign ram_addr = w_we ? {w_ch, w_addr} : {in_ch, ptr[in_ch]};

    novelty_weight_ram #(
        .CH_W   (CH_W),
        .PTR_W  (PTR_W),
        .DATA_W (DATA_W),
        .INIT_W (INIT_W)
    ) u_weights (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (w_data),
        .rdata (weight)
    );

    // Register the accepted sample; out-of-range channels leave no update behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upd_valid <= 1'b0;
            upd_ch    <= '0;
            upd_data  <= '0;
        end else begin
            upd_valid <= ram_re;
            if (ram_re) begin
                upd_ch   <= in_ch;
                upd_data <= in_data;
            end
        end
    end

    // Leak, integrate with saturation, compare the energy slice against the weight.
    always_comb begin
        e_cur    = energy[upd_ch];
        sum      = (ACC_W + 1)'(e_cur >> LEAK_SHIFT) + (ACC_W + 1)'(upd_data);
        upd_sat  = sum[ACC_W];
        e_new    = upd_sat ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        slice    = e_new[CMP_LSB +: DATA_W];
        hit      = (slice > weight);
        rise     = upd_valid & ~soft_clr & hit & ~novel[upd_ch];
        can_load = ~evt_valid | evt_ready;
    end

    // Per-channel energy, pointer, novelty and sticky saturation; a clear aborts the update in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            energy <= '0;
            ptr    <= '0;
            novel  <= '0;
            sat    <= '0;
        end else if (soft_clr) begin
            energy <= '0;
            ptr    <= '0;
            novel  <= '0;
            sat    <= '0;
        end else begin
            if (ram_re) begin
                ptr[in_ch] <= ptr[in_ch] + 1'b1;
            end
            if (upd_valid) begin
                energy[upd_ch] <= e_new;
                novel[upd_ch]  <= hit;
                if (upd_sat) begin
                    sat[upd_ch] <= 1'b1;
                end
            end
        end
    end

    // One-deep event register; a rising edge that finds it full and undrained is counted as lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_slice <= '0;
            drop_cnt  <= '0;
        end else begin
            if (rise && can_load) begin
                evt_valid <= 1'b1;
                evt_ch    <= upd_ch;
                evt_slice <= slice;
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (rise && !can_load && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule
